dmem_responder: RTL and testbench

- Single-port data-memory responder for the RISC-V CPU's load/store path; it is the memory-side end of the CPU data interface.
- Accepts one load or store request at a time over a valid/ready handshake.
- Holds the request for a programmable number of wait states, then returns one response (read data or write acknowledge, plus error flag) over a second valid/ready handshake.
- Used in the CPU testbench and SoC top to model realistic, non-zero-latency data memory.

---
 rtl/dmem_responder_if.sv | 47 ++++
 rtl/dmem_responder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : CPU data-memory bus. It carries one request channel
//               (valid/ready) and one response channel (valid/ready) between
//               a load/store unit (master) and a data memory (slave).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   req_valid    master->slave  request present
//   req_ready    slave->master  slave can accept a request
//   req_we       master->slave  1 = store, 0 = load
//   req_addr     master->slave  byte address
//   req_size     master->slave  00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned master->slave  zero-extend sub-word loads
//   req_wdata    master->slave  store data, LSB-justified
//   rsp_valid    slave->master  response present
//   rsp_ready    master->slave  master takes the response
//   rsp_rdata    slave->master  extended load result, 0 for stores/errors
//   rsp_err      slave->master  access fault
// ============================================================================
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-port data memory with a programmable number of wait
//               states. Accepts one load/store at a time, waits WAIT_CYCLES,
//               then returns one response (load data or store ack + error).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH_WORDS  memory size in 32-bit words (default 256)
//   WAIT_CYCLES  wait states between accept and response, 0..15 (default 1)
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   bus          dmem_responder_if.slave (request and response channels)
// Configuration macro:
//   DMEM_MISALIGN_TRAP_EN  defined   : misaligned half/word access faults
//                          undefined : low address bits are forced to the
//                                      natural alignment, no fault
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dmem_responder_if.slave   bus
);

    localparam int          AW           = $clog2(DEPTH_WORDS);
    localparam logic [32:0] C_ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  C_WAIT       = 4'(WAIT_CYCLES);

    localparam logic [1:0]  C_SZ_BYTE    = 2'b00;
    localparam logic [1:0]  C_SZ_HALF    = 2'b01;
    localparam logic [1:0]  C_SZ_WORD    = 2'b10;
    localparam logic [1:0]  C_SZ_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic        w_accept;
    logic        w_to_resp;
    logic        w_acc_we;
    logic [31:0] w_acc_addr;
    logic [1:0]  w_acc_size;
    logic        w_acc_uns;
    logic [31:0] w_acc_wdata;
    logic [1:0]  w_lane;
    logic        w_misalign;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rd_word;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load_data;
    logic [3:0]  w_be;
    logic [31:0] w_wr_lanes;
    logic        w_mem_we;

    // The accept is gated by reset so that nothing is taken while rst_ni is
    // low, even though the state register already reads IDLE.
    assign bus.req_ready = (state_q == S_IDLE) && rst_ni;
    assign w_accept      = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // ------------------------------------------------------------------------
    // Access operands. With zero wait states the memory access happens on the
    // accept edge itself, before the request registers hold the request, so
    // the live bus fields are used while in IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        if (state_q == S_IDLE) begin
            w_acc_we    = bus.req_we;
            w_acc_addr  = bus.req_addr;
            w_acc_size  = bus.req_size;
            w_acc_uns   = bus.req_unsigned;
            w_acc_wdata = bus.req_wdata;
        end else begin
            w_acc_we    = we_q;
            w_acc_addr  = addr_q;
            w_acc_size  = size_q;
            w_acc_uns   = uns_q;
            w_acc_wdata = wdata_q;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_lane     = w_acc_addr[1:0];
    assign w_misalign = ((w_acc_size == C_SZ_HALF) && w_acc_addr[0]) ||
                        ((w_acc_size == C_SZ_WORD) && (w_acc_addr[1:0] != 2'b00));
`else
    // Misaligned halves/words are silently snapped down to natural alignment.
    always_comb begin
        w_lane = w_acc_addr[1:0];
        if (w_acc_size == C_SZ_HALF) begin
            w_lane[0] = 1'b0;
        end else if (w_acc_size == C_SZ_WORD) begin
            w_lane = 2'b00;
        end
    end
    assign w_misalign = 1'b0;
`endif

    // The limit is a multiple of 4, so alignment forcing never changes the
    // outcome of the range check and the raw address can be compared.
    assign w_err = ({1'b0, w_acc_addr} >= C_ADDR_LIMIT) ||
                   (w_acc_size == C_SZ_RSVD) || w_misalign;

    assign w_idx     = w_acc_addr[AW+1:2];
    assign w_rd_word = mem_q[w_idx];

    // ------------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------------
    always_comb begin
        case (w_lane)
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
        w_rd_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

        case (w_acc_size)
            C_SZ_BYTE: w_load_data = w_acc_uns ? {24'd0, w_rd_byte}
                                               : {{24{w_rd_byte[7]}}, w_rd_byte};
            C_SZ_HALF: w_load_data = w_acc_uns ? {16'd0, w_rd_half}
                                               : {{16{w_rd_half[15]}}, w_rd_half};
            default:   w_load_data = w_rd_word;
        endcase
    end

    // ------------------------------------------------------------------------
    // Store lane enables; data is replicated so each lane sees its own bytes.
    // ------------------------------------------------------------------------
    always_comb begin
        w_be       = 4'b0000;
        w_wr_lanes = w_acc_wdata;
        case (w_acc_size)
            C_SZ_BYTE: begin
                w_be[w_lane] = 1'b1;
                w_wr_lanes   = {4{w_acc_wdata[7:0]}};
            end
            C_SZ_HALF: begin
                w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_lanes = {2{w_acc_wdata[15:0]}};
            end
            C_SZ_WORD: begin
                w_be = 4'b1111;
            end
            default: begin
                w_be = 4'b0000;
            end
        endcase
    end

    assign w_mem_we = w_to_resp && w_acc_we && !w_err;

    // ------------------------------------------------------------------------
    // FSM next state and request/response registers
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        w_to_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    cnt_d   = C_WAIT;
                    if (C_WAIT == 4'd0) begin
                        state_d   = S_RESP;
                        w_to_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot
                // wrap into a 15-cycle stall.
                if (cnt_q <= 4'd1) begin
                    cnt_d     = 4'd0;
                    state_d   = S_RESP;
                    w_to_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_to_resp) begin
            err_d   = w_err;
            rdata_d = (w_err || w_acc_we) ? 32'd0 : w_load_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory array: intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wr_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. Instance u0
//               runs with one wait state, instance u1 with zero wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if0.slave)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction on u0. lat = edges after the accept edge until the
    // response is visible. Request fields are scrambled after acceptance.
    task automatic do_txn(input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        int n;
        @(negedge clk);
        if0.req_valid    = 1'b1;
        if0.req_we       = we;
        if0.req_addr     = addr;
        if0.req_size     = size;
        if0.req_unsigned = uns;
        if0.req_wdata    = wdata;
        n = 0;
        while (!if0.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_ready never 1 (addr %h)", addr);
        end
        @(posedge clk);
        #1;
        if0.req_valid    = 1'b0;
        if0.req_we       = ~we;
        if0.req_addr     = ~addr;
        if0.req_size     = ~size;
        if0.req_unsigned = ~uns;
        if0.req_wdata    = ~wdata;
        lat = 0;
        while (!if0.rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = if0.rsp_rdata;
        err   = if0.rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        int          lat;
        rst_n = 1'b0;
        #1;
        vectors++; if (if0.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0", if0.req_ready); end
        vectors++; if (if0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", if0.rsp_valid); end
        vectors++; if (if0.rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_rsp_rdata: got %h want 0", if0.rsp_rdata); end
        vectors++; if (if0.rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err: got %b want 0", if0.rsp_err); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL rel_req_ready: got %b want 1", if0.req_ready); end

        do_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'h0000_0000, rd, er, lat);

        // Store abandoned by reset while in WAIT.
        @(negedge clk);
        if0.req_valid = 1'b1;
        if0.req_we    = 1'b1;
        if0.req_addr  = 32'h10;
        if0.req_size  = 2'b10;
        if0.req_wdata = 32'h1122_3344;
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
        vectors++; if (if0.req_ready !== 1'b0) begin miscompares++; $display("FAIL wait_req_ready: got %b want 0", if0.req_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (if0.req_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_req_ready: got %b want 0", if0.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL midrel_req_ready: got %b want 1", if0.req_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            vectors++; if (if0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrel_rsp_valid[%0d]: got %b want 0", k, if0.rsp_valid); end
        end
        do_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h0000_0000) begin miscompares++; $display("FAIL abandoned_store: load 0x10 got %h want 00000000", rd); end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_txn(1'b1, 32'h20, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL st_err: got %b want 0", er); end
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL st_rdata: got %h want 00000000", rd); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL st_latency: got %0d want 1", lat); end
        do_txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ld_word: got %h want deadbeef", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ld_err: got %b want 0", er); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ld_latency: got %0d want 1", lat); end
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_txn(1'b1, 32'h21, 2'b00, 1'b0, 32'hFFFF_FF80, rd, er, lat);
        do_txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hDEAD_80EF) begin miscompares++; $display("FAIL sb_word: got %h want dead80ef", rd); end
        do_txn(1'b0, 32'h21, 2'b00, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb: got %h want ffffff80", rd); end
        do_txn(1'b0, 32'h21, 2'b00, 1'b1, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu: got %h want 00000080", rd); end
        do_txn(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hFFFF_DEAD) begin miscompares++; $display("FAIL lh: got %h want ffffdead", rd); end
        do_txn(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h0000_DEAD) begin miscompares++; $display("FAIL lhu: got %h want 0000dead", rd); end
        do_txn(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hFFFF_FFEF) begin miscompares++; $display("FAIL lb0: got %h want ffffffef", rd); end
    endtask

    task automatic test_backpressure();
        int n;
        if0.rsp_ready = 1'b0;
        @(negedge clk);
        if0.req_valid = 1'b1;
        if0.req_we    = 1'b0;
        if0.req_addr  = 32'h20;
        if0.req_size  = 2'b10;
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
        n = 0;
        while (!if0.rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (if0.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", i, if0.rsp_valid); end
            vectors++; if (if0.rsp_rdata !== 32'hDEAD_80EF) begin miscompares++; $display("FAIL bp_rdata[%0d]: got %h want dead80ef", i, if0.rsp_rdata); end
            vectors++; if (if0.req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, if0.req_ready); end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        if0.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (if0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_consume_valid: got %b want 0", if0.rsp_valid); end
        vectors++; if (if0.req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_consume_ready: got %b want 1", if0.req_ready); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_txn(1'b1, 32'h0, 2'b10, 1'b0, 32'hA5A5_A5A5, rd, er, lat);
        do_txn(1'b1, 32'h400, 2'b10, 1'b0, 32'h1234_5678, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL oor_err: got %b want 1", er); end
        do_txn(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL oor_alias: got %h want a5a5a5a5", rd); end
        do_txn(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL oor_load: got err %b data %h want 1 00000000", er, rd); end
        do_txn(1'b1, 32'h3FC, 2'b10, 1'b0, 32'h0BAD_F00D, rd, er, lat);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL top_word_err: got %b want 0", er); end
        do_txn(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL top_word_data: got %h want 0badf00d", rd); end
        do_txn(1'b1, 32'h24, 2'b10, 1'b0, 32'h0102_0304, rd, er, lat);
        do_txn(1'b1, 32'h24, 2'b11, 1'b0, 32'hFFFF_FFFF, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL rsvd_st_err: got %b want 1", er); end
        do_txn(1'b0, 32'h24, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h0102_0304) begin miscompares++; $display("FAIL rsvd_st_mem: got %h want 01020304", rd); end
        do_txn(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL rsvd_ld: got err %b data %h want 1 00000000", er, rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_er;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_rd = 32'd0;
        exp_er = 1'b1;
`else
        exp_rd = 32'hDEAD_80EF;
        exp_er = 1'b0;
`endif
        do_txn(1'b0, 32'h22, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (er !== exp_er) begin miscompares++; $display("FAIL misalign_err: got %b want %b", er, exp_er); end
        vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL misalign_data: got %h want %h", rd, exp_rd); end
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_rd = 32'd0;
`else
        exp_rd = 32'hFFFF_80EF;
`endif
        do_txn(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (er !== exp_er || rd !== exp_rd) begin miscompares++; $display("FAIL misalign_half: got err %b data %h want %b %h", er, rd, exp_er, exp_rd); end
    endtask

    task automatic test_zero_wait();
        logic exp_v;
        @(negedge clk);
        if1.req_valid = 1'b1;
        if1.req_addr  = 32'h8;
        if1.req_size  = 2'b10;
        if1.req_wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 10; k++) begin
            if1.req_we = (k < 6);
            @(posedge clk);
            #1;
            exp_v = ((k % 2) == 0);
            vectors++; if (if1.rsp_valid !== exp_v) begin miscompares++; $display("FAIL zw_valid[%0d]: got %b want %b", k, if1.rsp_valid, exp_v); end
            if (exp_v) begin
                vectors++;
                if (if1.rsp_rdata !== ((k < 6) ? 32'd0 : 32'hCAFE_F00D)) begin
                    miscompares++;
                    $display("FAIL zw_rdata[%0d]: got %h want %h", k, if1.rsp_rdata, (k < 6) ? 32'd0 : 32'hCAFE_F00D);
                end
            end
            @(negedge clk);
        end
        if1.req_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = 32'd0;
        if0.req_size  = 2'b10; if0.req_unsigned = 1'b0; if0.req_wdata = 32'd0;
        if0.rsp_ready = 1'b1;
        if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = 32'd0;
        if1.req_size  = 2'b10; if1.req_unsigned = 1'b0; if1.req_wdata = 32'd0;
        if1.rsp_ready = 1'b1;

        test_reset();
        test_word_roundtrip();
        test_subword();
        test_backpressure();
        test_errors();
        test_misalign();
        test_zero_wait();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
